// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write bus of the program loader.
// master = stream producer / memory observer, slave = the loader.
interface prog_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_sel, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Boot/run sequencer for the 8-bit accumulator CPU: loads instruction/data memory
// from a byte stream, then runs the CPU and counts cycles until HALT or timeout.
module prog_loader #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int RST_CYCLES = 1,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    prog_loader_if.slave     bus,
    output logic             cpu_rst,
    input  logic             cpu_halt,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             err,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {S_HDR, S_LEN, S_DATA, S_CPU_RST, S_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        rem_q, rem_d;
    logic              sel_q, sel_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;

    logic              hs;
    logic [1:0]        cmd;
    logic [CNT_W-1:0]  cnt_inc;

    assign hs      = bus.in_valid & bus.in_ready;
    assign cmd     = bus.in_data[DATA_W-1:DATA_W-2];
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HDR;
            addr_q    <= '0;
            rem_q     <= '0;
            sel_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            rcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            sel_q     <= sel_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        sel_d     = sel_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        unique case (state_q)
            S_HDR: begin
                // cpu_rst stays wherever the last run left it until a header arrives
                if (hs) begin
                    cpu_rst_d = 1'b1;
                    unique case (cmd)
                        2'b00, 2'b01: begin
                            addr_d  = bus.in_data[ADDR_W-1:0];
                            sel_d   = cmd[0];
                            state_d = S_LEN;
                        end
                        2'b10: begin
                            timeout_d = 1'b0;
                            cnt_d     = '0;
                            rcnt_d    = '0;
                            state_d   = S_CPU_RST;
                        end
                        2'b11: err_d = 1'b1;
                    endcase
                end
            end
            S_LEN: begin
                if (hs) begin
                    rem_d   = bus.in_data[4:0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (hs) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (rem_q == 5'd0) state_d = S_HDR;
                    else               rem_d   = rem_q - 5'd1;
                end
            end
            S_CPU_RST: begin
                if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
                    cpu_rst_d = 1'b0;
                    state_d   = S_RUN;
                end else begin
                    rcnt_d = rcnt_q + RC_W'(1);
                end
            end
            S_RUN: begin
                if (cpu_halt) begin
                    done_d  = 1'b1;
                    state_d = S_HDR;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(MAX_CYCLES)) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b1;
                        state_d   = S_HDR;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    assign bus.in_ready  = (state_q == S_HDR) || (state_q == S_LEN) || (state_q == S_DATA);
    assign bus.mem_we    = (state_q == S_DATA) && bus.in_valid;
    assign bus.mem_wdata = (state_q == S_DATA) ? bus.in_data : '0;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_sel   = sel_q;

    assign busy        = (state_q == S_CPU_RST) || (state_q == S_RUN);
    assign cpu_rst     = cpu_rst_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign err         = err_q;
    assign cycle_count = cnt_q;
endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: expected writes and run results are
// queued by the driver and checked by a monitor whenever the DUT presents them.
module tb_prog_loader;
    localparam int MAXC = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rst, cpu_halt, busy, done, timeout, err;
    logic [15:0] cycle_count;

    prog_loader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    prog_loader #(.ADDR_W(5), .DATA_W(8), .RST_CYCLES(1), .CNT_W(16), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst(rst), .bus(bus), .cpu_rst(cpu_rst), .cpu_halt(cpu_halt),
        .busy(busy), .done(done), .timeout(timeout), .err(err), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic sel; logic [4:0] addr; logic [7:0] data;} wr_t;
    typedef struct {int cnt; logic to; logic crst;} run_t;

    int   checks = 0, errors = 0;
    wr_t  wq[$];
    run_t rq[$];
    logic [7:0] bytes[32];
    int   stalls[32];
    logic exp_we, model_to, model_err;
    int   last_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) chk("done_pulse_width", done, 1'b0);
            prev_done = done;
            chk("mem_we", bus.mem_we, exp_we);
            if (bus.mem_we && exp_we && wq.size() > 0) begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_sel", bus.mem_sel, e.sel);
                chk("wr_addr", bus.mem_addr, e.addr);
                chk("wr_data", bus.mem_wdata, e.data);
            end
            if (done) begin
                if (rq.size() == 0) chk("unexpected_done", done, 1'b0);
                else begin
                    run_t r;
                    r = rq.pop_front();
                    chk("cycle_count", cycle_count, r.cnt);
                    chk("timeout", timeout, r.to);
                    chk("cpu_rst_after_run", cpu_rst, r.crst);
                    chk("in_ready_after_run", bus.in_ready, 1'b1);
                    chk("busy_after_run", busy, 1'b0);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte; the loader must be ready, so transfer takes exactly one edge.
    task automatic drive(input logic [7:0] b, input logic is_data);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        exp_we       = is_data;
        chk("in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        exp_we       = 1'b0;
    endtask

    task automatic load(input logic sel, input logic [4:0] addr, input int n,
                        input logic [2:0] hi, input logic b5);
        drive({1'b0, sel, b5, addr}, 1'b0);
        drive({hi, 5'(n - 1)}, 1'b0);
        for (int i = 0; i < n; i++) begin
            repeat (stalls[i]) tick();
            wq.push_back('{sel, 5'(addr + i), bytes[i]});
            drive(bytes[i], 1'b1);
        end
        chk("busy_after_load", busy, 1'b0);
    endtask

    // k = RUN cycle in which cpu_halt rises (1-based); 0 = never.
    task automatic run(input int k);
        run_t e;
        int   c, guard;
        chk("timeout_hold", timeout, model_to);
        chk("count_hold", cycle_count, last_cnt);
        if (k >= 1) e = '{k - 1, 1'b0, 1'b0};
        else        e = '{MAXC, 1'b1, 1'b1};
        rq.push_back(e);
        model_to = e.to;
        last_cnt = e.cnt;
        drive({2'b10, 6'($urandom)}, 1'b0);
        chk("timeout_cleared", timeout, 1'b0);
        chk("busy_cpu_rst", busy, 1'b1);
        chk("cpu_rst_held", cpu_rst, 1'b1);
        chk("count_cleared", cycle_count, 0);
        tick();
        chk("cpu_rst_run", cpu_rst, 1'b0);
        chk("in_ready_run", bus.in_ready, 1'b0);
        if (k >= 1) begin
            c = 1;
            while (c < k) begin
                tick();
                c++;
            end
            cpu_halt = 1'b1;
        end
        guard = 0;
        while (!done && guard < MAXC + 5) begin
            tick();
            guard++;
        end
        chk("run_ended", done, 1'b1);
        cpu_halt = 1'b0;
        tick();
    endtask

    task automatic check_reset();
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_sel", bus.mem_sel, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_done", done, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_count", cycle_count, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        cpu_halt     = 1'b0;
        rst          = 1'b1;
        exp_we       = 1'b0;
        model_to     = 1'b0;
        model_err    = 1'b0;
        last_cnt     = 0;
        for (int i = 0; i < 32; i++) stalls[i] = 0;
        fork
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (2) tick();
        check_reset();
        rst = 1'b0;
        fork
            monitor();
        join_none
        tick();

        // instruction load 0x03,0x01,0xE2,0x00
        bytes[0] = 8'hE2; bytes[1] = 8'h00;
        load(1'b0, 5'd3, 2, 3'd0, 1'b0);
        // data load with address wrap and a 3-cycle stall: 0x5F,0x01,0xAA,..,0xBB
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; stalls[1] = 3;
        load(1'b1, 5'd31, 2, 3'd0, 1'b0);
        stalls[1] = 0;

        run(13);
        run(0);
        run(MAXC);
        run(1);

        drive({2'b11, 6'd0}, 1'b0);
        model_err = 1'b1;
        chk("err_set", err, 1'b1);
        chk("cpu_rst_after_hdr", cpu_rst, 1'b1);

        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                int n;
                n = $urandom_range(1, 32);
                for (int i = 0; i < n; i++) begin
                    bytes[i]  = 8'($urandom);
                    stalls[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                end
                load(1'($urandom), 5'($urandom), n, 3'($urandom), 1'($urandom));
            end else if (r <= 8) begin
                run($urandom_range(0, MAXC));
            end else begin
                drive({2'b11, 6'($urandom)}, 1'b0);
                model_err = 1'b1;
            end
            chk("err_sticky", err, model_err);
        end

        // reset in the middle of a load: 0x00,0x04,0x11 then rst
        drive(8'h00, 1'b0);
        drive(8'h04, 1'b0);
        wq.push_back('{1'b0, 5'd0, 8'h11});
        drive(8'h11, 1'b1);
        rst = 1'b1;
        tick();
        check_reset();
        rst = 1'b0;
        model_err = 1'b0;
        model_to  = 1'b0;
        last_cnt  = 0;
        tick();
        chk("no_write_after_rst", bus.mem_we, 1'b0);

        repeat (2) tick();
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
